// File: rtl/biquad_sequencer_if.sv
// biquad_sequencer_if: strobe, coefficient, multiplier and result signals of the biquad sequencer
interface biquad_sequencer_if #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
);
  localparam int AW = $clog2(CHANNELS * 5);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic                         sample_strobe;
  logic [CHANNELS*BITSIZE-1:0]  in_data;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic [BITSIZE-1:0]           coef_wdata;
  logic [BITSIZE-1:0]           mul_a;
  logic [BITSIZE-1:0]           mul_b;
  logic [2*BITSIZE-1:0]         mul_p;
  logic [BITSIZE-1:0]           out_data;
  logic [CW-1:0]                out_chan;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;
  modport master (
    output sample_strobe, in_data, coef_we, coef_addr, coef_wdata, mul_p,
    input  mul_a, mul_b, out_data, out_chan, out_valid, busy, overrun
  );
  modport slave (
    input  sample_strobe, in_data, coef_we, coef_addr, coef_wdata, mul_p,
    output mul_a, mul_b, out_data, out_chan, out_valid, busy, overrun
  );
endinterface

// File: rtl/biquad_sequencer.sv
// biquad_sequencer: time-multiplexed multi-channel biquad on one external multiplier
// Define BIQUAD_SAT_EN to saturate sums instead of wrapping them.
module biquad_sequencer #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
) (
  input logic               clk,
  input logic               rst,
  biquad_sequencer_if.slave bus
);
  localparam int B  = BITSIZE;
  localparam int NC = CHANNELS * 5;
  localparam int AW = $clog2(NC);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [CW-1:0]  chan_q, chan_d;
  logic [B-1:0]   x_q [CHANNELS];
  logic [B-1:0]   x_d [CHANNELS];
  logic [B-1:0]   z1_q [CHANNELS];
  logic [B-1:0]   z1_d [CHANNELS];
  logic [B-1:0]   z2_q [CHANNELS];
  logic [B-1:0]   z2_d [CHANNELS];
  logic [B-1:0]   cs_q [NC];
  logic [B-1:0]   cs_d [NC];
  logic [B-1:0]   ca_q [NC];
  logic [B-1:0]   ca_d [NC];
  logic [B-1:0]   y_q, y_d, t_q, t_d;
  logic [B-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]  out_chan_q, out_chan_d;
  logic           out_valid_q, out_valid_d;
  logic           overrun_q, overrun_d;
  logic [B-1:0]   p;
  logic [AW-1:0]  base;
  logic [2:0]     kmap;
  logic           run, issue, unused_p;
  function automatic logic [B-1:0] sum(input logic [B-1:0] a, input logic [B-1:0] b, input logic sub);
`ifdef BIQUAD_SAT_EN
    logic signed [B:0] s;
    s = sub ? $signed({a[B-1], a}) - $signed({b[B-1], b}) : $signed({a[B-1], a}) + $signed({b[B-1], b});
    return (s[B] != s[B-1]) ? {s[B], {(B-1){~s[B]}}} : s[B-1:0];
`else
    return sub ? a - b : a + b;
`endif
  endfunction
  assign p        = bus.mul_p[2*B-2 -: B];
  assign unused_p = ^{bus.mul_p[2*B-1], bus.mul_p[B-2:0]};
  assign run      = state_q == RUN;
  assign issue    = run && step_q <= 3'd4;
  assign base     = AW'(5 * int'(chan_q));
  // issue order a0, a1, b1, a2, b2 maps steps 0..4 onto coefficient slots 0,1,3,2,4
  assign kmap     = step_q == 3'd2 ? 3'd3 : step_q == 3'd3 ? 3'd2 : step_q > 3'd4 ? 3'd0 : step_q;
  assign bus.mul_a     = !issue ? '0 : (step_q == 3'd2 || step_q == 3'd4) ? y_q : x_q[chan_q];
  assign bus.mul_b     = issue ? ca_q[base + AW'(kmap)] : '0;
  assign bus.busy      = state_q != IDLE;
  assign bus.overrun   = overrun_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    chan_d      = chan_q;
    x_d         = x_q;
    z1_d        = z1_q;
    z2_d        = z2_q;
    cs_d        = cs_q;
    ca_d        = ca_q;
    y_d         = y_q;
    t_d         = t_q;
    out_valid_d = run && step_q == 3'd4;
    out_data_d  = out_valid_d ? y_q : out_data_q;
    out_chan_d  = out_valid_d ? chan_q : out_chan_q;
    overrun_d   = overrun_q | (bus.sample_strobe && state_q != IDLE);
    if (bus.coef_we && int'(bus.coef_addr) < NC) cs_d[bus.coef_addr] = bus.coef_wdata;
    // active bank takes the pre-write shadow, so a coincident write waits for the next frame
    if (state_q == IDLE && bus.sample_strobe) begin
      state_d = RUN;
      step_d  = '0;
      chan_d  = '0;
      ca_d    = cs_q;
      for (int i = 0; i < CHANNELS; i++) x_d[i] = bus.in_data[i*B +: B];
    end
    if (run) begin
      step_d = step_q == 3'd5 ? 3'd0 : step_q + 3'd1;
      if (step_q == 3'd5) begin
        chan_d  = chan_q + CW'(1);
        state_d = int'(chan_q) == CHANNELS - 1 ? DONE : RUN;
      end
      y_d = step_q == 3'd1 ? sum(p, z1_q[chan_q], 1'b0) : y_q;
      t_d = step_q == 3'd2 ? sum(p, z2_q[chan_q], 1'b0) : step_q == 3'd4 ? p : t_q;
      if (step_q == 3'd3) z1_d[chan_q] = sum(t_q, p, 1'b1);
      if (step_q == 3'd5) z2_d[chan_q] = sum(t_q, p, 1'b1);
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      chan_q      <= '0;
      x_q         <= '{default: '0};
      z1_q        <= '{default: '0};
      z2_q        <= '{default: '0};
      cs_q        <= '{default: '0};
      ca_q        <= '{default: '0};
      y_q         <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      chan_q      <= chan_d;
      x_q         <= x_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      cs_q        <= cs_d;
      ca_q        <= ca_d;
      y_q         <= y_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule
